// File: rtl/hazard_scoreboard_if.sv
// Decode/Execute/Writeback hazard-control bundle between the pipeline (master)
// and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = $clog2(NREG)
);
    logic            valid_D;
    logic [AW-1:0]   rs1_D;
    logic [AW-1:0]   rs2_D;
    logic            rs1_used_D;
    logic            rs2_used_D;
    logic [AW-1:0]   rd_D;
    logic            rd_we_D;
    logic            mc_D;
    logic            redirect_E;
    logic            wb_valid_W;
    logic [AW-1:0]   wb_rd_W;

    logic            StallF;
    logic            StallD;
    logic            FlushD;
    logic            FlushE;
    logic            issue_D;
    logic            fwdA_D;
    logic            fwdB_D;
    logic            mc_busy;
    logic            mc_done;
    logic [NREG-1:0] pending;
    logic            sb_err;

    modport master (
        output valid_D, rs1_D, rs2_D, rs1_used_D, rs2_used_D, rd_D, rd_we_D, mc_D,
        output redirect_E, wb_valid_W, wb_rd_W,
        input  StallF, StallD, FlushD, FlushE, issue_D, fwdA_D, fwdB_D,
        input  mc_busy, mc_done, pending, sb_err
    );

    modport slave (
        input  valid_D, rs1_D, rs2_D, rs1_used_D, rs2_used_D, rd_D, rd_we_D, mc_D,
        input  redirect_E, wb_valid_W, wb_rd_W,
        output StallF, StallD, FlushD, FlushE, issue_D, fwdA_D, fwdB_D,
        output mc_busy, mc_done, pending, sb_err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register scoreboard with RAW/WAW/multicycle-unit hazard detection, Writeback
// forwarding and stall/flush generation for an in-order pipeline.
module hazard_scoreboard #(
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = $clog2(NREG),
    parameter int unsigned MC_LAT = 4,
    parameter bit          FWD_EN = 1'b1
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave bus
);
    localparam logic [3:0] McLatCnt = 4'(MC_LAT);

    typedef enum logic {StIdle, StBusy} mc_state_e;

    logic [NREG-1:0] pending_q, pending_d;
    logic [3:0]      cnt_q, cnt_d;
    mc_state_e       mc_state_q;
    logic            mc_done_q;
    logic            sb_err_q;

    logic wb_live;
    logic src1_pend, src2_pend;
    logic wb_hit1, wb_hit2;
    logic haz1, haz2, waw, mc_conflict;
    logic stall, issue;

    always_comb begin
        wb_live     = bus.wb_valid_W && (bus.wb_rd_W != '0);
        src1_pend   = bus.rs1_used_D && (bus.rs1_D != '0) && pending_q[bus.rs1_D];
        src2_pend   = bus.rs2_used_D && (bus.rs2_D != '0) && pending_q[bus.rs2_D];
        wb_hit1     = wb_live && (bus.wb_rd_W == bus.rs1_D);
        wb_hit2     = wb_live && (bus.wb_rd_W == bus.rs2_D);
        haz1        = src1_pend && !(FWD_EN && wb_hit1);
        haz2        = src2_pend && !(FWD_EN && wb_hit2);
        // A write retiring this cycle frees the destination for reuse.
        waw         = bus.rd_we_D && (bus.rd_D != '0) && pending_q[bus.rd_D] &&
                      !(wb_live && (bus.wb_rd_W == bus.rd_D));
        // Counter at 1 finishes this cycle, so a new mc op may follow directly.
        mc_conflict = bus.mc_D && (cnt_q > 4'd1);
        stall       = bus.valid_D && (haz1 || haz2 || waw || mc_conflict) && !bus.redirect_E;
        issue       = bus.valid_D && !stall && !bus.redirect_E;
    end

    always_comb begin
        pending_d = pending_q;
        if (wb_live) begin
            pending_d[bus.wb_rd_W] = 1'b0;
        end
        // Set after clear so a same-cycle issue to the retiring register wins.
        if (issue && bus.rd_we_D && (bus.rd_D != '0)) begin
            pending_d[bus.rd_D] = 1'b1;
        end
        pending_d[0] = 1'b0;

        cnt_d = cnt_q;
        if (issue && bus.mc_D) begin
            cnt_d = McLatCnt;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q  <= '0;
            cnt_q      <= 4'd0;
            mc_state_q <= StIdle;
            mc_done_q  <= 1'b0;
            sb_err_q   <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            mc_state_q <= (cnt_d != 4'd0) ? StBusy : StIdle;
            mc_done_q  <= (cnt_q == 4'd1);
            if (wb_live && !pending_q[bus.wb_rd_W]) begin
                sb_err_q <= 1'b1;
            end
        end
    end

    assign bus.StallF  = stall;
    assign bus.StallD  = stall;
    assign bus.FlushD  = bus.redirect_E;
    assign bus.FlushE  = stall || bus.redirect_E;
    assign bus.issue_D = issue;
    assign bus.fwdA_D  = FWD_EN && src1_pend && wb_hit1;
    assign bus.fwdB_D  = FWD_EN && src2_pend && wb_hit2;
    assign bus.mc_busy = (mc_state_q == StBusy);
    assign bus.mc_done = mc_done_q;
    assign bus.pending = pending_q;
    assign bus.sb_err  = sb_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one forwarding instance and one with
// forwarding disabled, both driven from the same stimulus.
module tb_hazard_scoreboard;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    hazard_scoreboard_if #(.NREG(32), .AW(5)) bus ();
    hazard_scoreboard_if #(.NREG(32), .AW(5)) bus_nf ();

    assign bus_nf.valid_D    = bus.valid_D;
    assign bus_nf.rs1_D      = bus.rs1_D;
    assign bus_nf.rs2_D      = bus.rs2_D;
    assign bus_nf.rs1_used_D = bus.rs1_used_D;
    assign bus_nf.rs2_used_D = bus.rs2_used_D;
    assign bus_nf.rd_D       = bus.rd_D;
    assign bus_nf.rd_we_D    = bus.rd_we_D;
    assign bus_nf.mc_D       = bus.mc_D;
    assign bus_nf.redirect_E = bus.redirect_E;
    assign bus_nf.wb_valid_W = bus.wb_valid_W;
    assign bus_nf.wb_rd_W    = bus.wb_rd_W;

    hazard_scoreboard #(.NREG(32), .AW(5), .MC_LAT(4), .FWD_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    hazard_scoreboard #(.NREG(32), .AW(5), .MC_LAT(4), .FWD_EN(1'b0)) dut_nf (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.valid_D    = 1'b0;
        bus.rs1_D      = '0;
        bus.rs2_D      = '0;
        bus.rs1_used_D = 1'b0;
        bus.rs2_used_D = 1'b0;
        bus.rd_D       = '0;
        bus.rd_we_D    = 1'b0;
        bus.mc_D       = 1'b0;
        bus.redirect_E = 1'b0;
        bus.wb_valid_W = 1'b0;
        bus.wb_rd_W    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #1;
        n_vec++;
        if (bus.pending !== 32'h0) begin
            n_err++; $display("FAIL reset_pending got=%h exp=%h", bus.pending, 32'h0);
        end
        n_vec++;
        if ({bus.mc_busy, bus.mc_done, bus.sb_err} !== 3'b000) begin
            n_err++; $display("FAIL reset_mc_err got=%b exp=000",
                              {bus.mc_busy, bus.mc_done, bus.sb_err});
        end
        bus.valid_D = 1'b1; bus.rs1_D = 5'd5; bus.rs1_used_D = 1'b1;
        #1;
        n_vec++;
        if ({bus.StallD, bus.FlushE, bus.issue_D} !== 3'b001) begin
            n_err++; $display("FAIL reset_no_stall got=%b exp=001",
                              {bus.StallD, bus.FlushE, bus.issue_D});
        end
        clear_inputs();
        step();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_raw_fwd();
        do_reset();
        bus.valid_D = 1'b1; bus.rd_D = 5'd5; bus.rd_we_D = 1'b1;
        #1;
        n_vec++;
        if (bus.issue_D !== 1'b1) begin
            n_err++; $display("FAIL raw_first_issue got=%b exp=1", bus.issue_D);
        end
        step();
        n_vec++;
        if (bus.pending !== 32'h20) begin
            n_err++; $display("FAIL raw_pending_set got=%h exp=%h", bus.pending, 32'h20);
        end
        bus.rd_we_D = 1'b0; bus.rd_D = 5'd0; bus.rs1_D = 5'd5; bus.rs1_used_D = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++;
            if ({bus.StallF, bus.StallD, bus.FlushE, bus.issue_D, bus.fwdA_D} !== 5'b11100) begin
                n_err++; $display("FAIL raw_stall[%0d] got=%b exp=11100", c,
                    {bus.StallF, bus.StallD, bus.FlushE, bus.issue_D, bus.fwdA_D});
            end
            step();
        end
        bus.wb_valid_W = 1'b1; bus.wb_rd_W = 5'd5;
        #1;
        n_vec++;
        if ({bus.StallD, bus.issue_D, bus.fwdA_D, bus.fwdB_D} !== 4'b0110) begin
            n_err++; $display("FAIL raw_forward got=%b exp=0110",
                              {bus.StallD, bus.issue_D, bus.fwdA_D, bus.fwdB_D});
        end
        step();
        clear_inputs();
        #1;
        n_vec++;
        if ({bus.pending, bus.sb_err} !== 33'h0) begin
            n_err++; $display("FAIL raw_cleared got=%h/%b exp=0/0", bus.pending, bus.sb_err);
        end
    endtask

    task automatic test_no_fwd();
        do_reset();
        bus.valid_D = 1'b1; bus.rd_D = 5'd5; bus.rd_we_D = 1'b1;
        step();
        bus.rd_we_D = 1'b0; bus.rd_D = 5'd0; bus.rs1_D = 5'd5; bus.rs1_used_D = 1'b1;
        bus.wb_valid_W = 1'b1; bus.wb_rd_W = 5'd5;
        #1;
        n_vec++;
        if ({bus_nf.StallD, bus_nf.issue_D, bus_nf.fwdA_D} !== 3'b100) begin
            n_err++; $display("FAIL nofwd_wb_cycle got=%b exp=100",
                              {bus_nf.StallD, bus_nf.issue_D, bus_nf.fwdA_D});
        end
        step();
        bus.wb_valid_W = 1'b0; bus.wb_rd_W = 5'd0;
        #1;
        n_vec++;
        if ({bus_nf.StallD, bus_nf.issue_D, bus_nf.fwdA_D, bus_nf.pending[5]} !== 4'b0100) begin
            n_err++; $display("FAIL nofwd_issue got=%b exp=0100",
                {bus_nf.StallD, bus_nf.issue_D, bus_nf.fwdA_D, bus_nf.pending[5]});
        end
        step();
        clear_inputs();
    endtask

    task automatic test_multicycle();
        do_reset();
        bus.valid_D = 1'b1; bus.mc_D = 1'b1;
        #1;
        n_vec++;
        if ({bus.issue_D, bus.mc_busy} !== 2'b10) begin
            n_err++; $display("FAIL mc_c0 got=%b exp=10", {bus.issue_D, bus.mc_busy});
        end
        step();
        clear_inputs();
        #1;
        n_vec++;
        if ({bus.mc_busy, bus.mc_done} !== 2'b10) begin
            n_err++; $display("FAIL mc_c1 got=%b exp=10", {bus.mc_busy, bus.mc_done});
        end
        step();
        bus.valid_D = 1'b1; bus.mc_D = 1'b1;
        for (int c = 2; c < 4; c++) begin
            #1;
            n_vec++;
            if ({bus.StallD, bus.issue_D, bus.mc_busy} !== 3'b101) begin
                n_err++; $display("FAIL mc_stall_c%0d got=%b exp=101", c,
                                  {bus.StallD, bus.issue_D, bus.mc_busy});
            end
            step();
        end
        #1;
        n_vec++;
        if ({bus.StallD, bus.issue_D, bus.mc_busy, bus.mc_done} !== 4'b0110) begin
            n_err++; $display("FAIL mc_b2b_c4 got=%b exp=0110",
                              {bus.StallD, bus.issue_D, bus.mc_busy, bus.mc_done});
        end
        step();
        clear_inputs();
        #1;
        n_vec++;
        if ({bus.mc_busy, bus.mc_done} !== 2'b11) begin
            n_err++; $display("FAIL mc_done_reload got=%b exp=11", {bus.mc_busy, bus.mc_done});
        end
        step();
        n_vec++;
        if (bus.mc_done !== 1'b0) begin
            n_err++; $display("FAIL mc_done_width got=%b exp=0", bus.mc_done);
        end
        step(); step(); step();
        n_vec++;
        if ({bus.mc_busy, bus.mc_done} !== 2'b01) begin
            n_err++; $display("FAIL mc_done_final got=%b exp=01", {bus.mc_busy, bus.mc_done});
        end
    endtask

    task automatic test_redirect();
        do_reset();
        bus.valid_D = 1'b1; bus.rd_D = 5'd5; bus.rd_we_D = 1'b1;
        step();
        bus.rs1_D = 5'd5; bus.rs1_used_D = 1'b1; bus.rd_D = 5'd6; bus.mc_D = 1'b1;
        bus.redirect_E = 1'b1;
        #1;
        n_vec++;
        if ({bus.FlushD, bus.FlushE, bus.StallD, bus.StallF, bus.issue_D} !== 5'b11000) begin
            n_err++; $display("FAIL redirect_ctrl got=%b exp=11000",
                {bus.FlushD, bus.FlushE, bus.StallD, bus.StallF, bus.issue_D});
        end
        step();
        clear_inputs();
        #1;
        n_vec++;
        if ({bus.pending, bus.mc_busy} !== {32'h20, 1'b0}) begin
            n_err++; $display("FAIL redirect_state got=%h/%b exp=%h/0",
                              bus.pending, bus.mc_busy, 32'h20);
        end
    endtask

    task automatic test_sb_err();
        do_reset();
        bus.wb_valid_W = 1'b1; bus.wb_rd_W = 5'd0;
        step();
        n_vec++;
        if (bus.sb_err !== 1'b0) begin
            n_err++; $display("FAIL sberr_x0_ignored got=%b exp=0", bus.sb_err);
        end
        bus.wb_rd_W = 5'd7;
        step();
        clear_inputs();
        n_vec++;
        if (bus.sb_err !== 1'b1) begin
            n_err++; $display("FAIL sberr_set got=%b exp=1", bus.sb_err);
        end
        step(); step();
        n_vec++;
        if (bus.sb_err !== 1'b1) begin
            n_err++; $display("FAIL sberr_sticky got=%b exp=1", bus.sb_err);
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (bus.sb_err !== 1'b0) begin
            n_err++; $display("FAIL sberr_async_clear got=%b exp=0", bus.sb_err);
        end
        step();
        reset = 1'b1;
    endtask

    task automatic test_set_wins();
        do_reset();
        bus.valid_D = 1'b1; bus.rd_D = 5'd3; bus.rd_we_D = 1'b1;
        step();
        bus.valid_D = 1'b1;
        #1;
        n_vec++;
        if ({bus.StallD, bus.issue_D} !== 2'b10) begin
            n_err++; $display("FAIL waw_stall got=%b exp=10", {bus.StallD, bus.issue_D});
        end
        bus.wb_valid_W = 1'b1; bus.wb_rd_W = 5'd3;
        #1;
        n_vec++;
        if ({bus.StallD, bus.issue_D} !== 2'b01) begin
            n_err++; $display("FAIL waw_wb_release got=%b exp=01", {bus.StallD, bus.issue_D});
        end
        step();
        n_vec++;
        if (bus.pending !== 32'h8) begin
            n_err++; $display("FAIL set_wins got=%h exp=%h", bus.pending, 32'h8);
        end
        clear_inputs();
        bus.wb_valid_W = 1'b1; bus.wb_rd_W = 5'd3;
        step();
        clear_inputs();
        bus.valid_D = 1'b1; bus.rd_D = 5'd0; bus.rd_we_D = 1'b1;
        step();
        clear_inputs();
        n_vec++;
        if ({bus.pending, bus.sb_err} !== 33'h0) begin
            n_err++; $display("FAIL rd0_ignored got=%h/%b exp=0/0", bus.pending, bus.sb_err);
        end
    endtask

    task automatic test_reset_mid_mc();
        do_reset();
        bus.valid_D = 1'b1; bus.mc_D = 1'b1;
        step();
        clear_inputs();
        step();
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (bus.mc_busy !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_busy got=%b exp=0", bus.mc_busy);
        end
        step();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            n_vec++;
            if ({bus.mc_busy, bus.mc_done} !== 2'b00) begin
                n_err++; $display("FAIL mid_reset_no_done[%0d] got=%b exp=00", c,
                                  {bus.mc_busy, bus.mc_done});
            end
        end
        bus.valid_D = 1'b1; bus.rd_D = 5'd9; bus.rd_we_D = 1'b1;
        step();
        clear_inputs();
        n_vec++;
        if (bus.pending !== 32'h200) begin
            n_err++; $display("FAIL post_reset_issue got=%h exp=%h", bus.pending, 32'h200);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_raw_fwd();
        test_no_fwd();
        test_multicycle();
        test_redirect();
        test_sb_err();
        test_set_wins();
        test_reset_mid_mc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
